// File: rtl/emesh_axi_pkg.sv
// Shared EMesh packet layout, AXI encodings and write-lane packing helpers.
package emesh_axi_pkg;

   localparam int PKT_W      = 104;
   localparam int ACCESS_BIT = 0;
   localparam int WRITE_BIT  = 1;
   localparam int DM_LSB     = 2;
   localparam int DM_W       = 2;
   localparam int CTRL_LSB   = 4;
   localparam int CTRL_W     = 4;
   localparam int DST_LSB    = 8;
   localparam int DATA_LSB   = 40;
   localparam int SRC_LSB    = 72;
   localparam int ADDR_W     = 32;

   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
   localparam logic [1:0] RESP_SLVERR   = 2'b10;
   localparam logic [1:0] RESP_DECERR   = 2'b11;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } wr_state_e;

   // Replicate the payload across the 64-bit bus so any lane selected by wstrb carries it.
   function automatic logic [63:0] pack_wdata(input logic [1:0]  dm,
                                              input logic [31:0] data,
                                              input logic [31:0] src);
      case (dm)
         2'd0:    return {8{data[7:0]}};
         2'd1:    return {4{data[15:0]}};
         2'd2:    return {2{data}};
         default: return {src, data};
      endcase
   endfunction

   // Byte strobes follow the size-aligned portion of the low address bits.
   function automatic logic [7:0] pack_wstrb(input logic [1:0] dm,
                                             input logic [2:0] a);
      case (dm)
         2'd0:    return 8'h01 << a;
         2'd1:    return 8'h03 << {a[2:1], 1'b0};
         2'd2:    return 8'h0F << {a[2], 2'b00};
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/emaxi_rr_arb.sv
// Round-robin arbiter: first requester at or after the pointer (wrapping) wins;
// the pointer moves past the winner only when the caller confirms the grant.
module emaxi_rr_arb #(
   parameter int NREQ  = 2,
   parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic             upd,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_vld
);

   logic [IDX_W-1:0] ptr;

   // Search from the pointer upward, wrapping at NREQ.
   always_comb begin : arb_search
      int j;
      j         = 0;
      grant_idx = '0;
      grant_vld = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!grant_vld && req[j]) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'(j);
         end
      end
   end

   // Advance the pointer to the slot after the confirmed winner.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (upd)
         ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
   end

endmodule

// File: rtl/emaxi_wr_sched.sv
// EMesh write scheduler: round-robin accepts EMesh write packets and issues each
// as a single-beat AXI write with independent AW/W handshakes, bounding the
// number of writes awaiting a B response.
module emaxi_wr_sched
   import emesh_axi_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int ID_W      = 4,
   parameter int MAX_OUTST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_access,
   input  logic [NREQ*PKT_W-1:0] req_packet,
   output logic [NREQ-1:0]      req_wait,
   output logic [ID_W-1:0]      m_axi_awid,
   output logic [ADDR_W-1:0]    m_axi_awaddr,
   output logic [7:0]           m_axi_awlen,
   output logic [2:0]           m_axi_awsize,
   output logic [1:0]           m_axi_awburst,
   output logic                 m_axi_awlock,
   output logic [3:0]           m_axi_awcache,
   output logic [2:0]           m_axi_awprot,
   output logic [3:0]           m_axi_awqos,
   output logic                 m_axi_awvalid,
   input  logic                 m_axi_awready,
   output logic [63:0]          m_axi_wdata,
   output logic [7:0]           m_axi_wstrb,
   output logic                 m_axi_wlast,
   output logic                 m_axi_wvalid,
   input  logic                 m_axi_wready,
   input  logic                 m_axi_bvalid,
   input  logic [1:0]           m_axi_bresp,
   output logic                 m_axi_bready,
   output logic [3:0]           outst_cnt,
   output logic [2:0]           err_sticky
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   wr_state_e        state;
   wr_state_e        state_nxt;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_vld;
   logic [PKT_W-1:0] pkt;
   logic             accept;
   logic             load;
   logic             drop;
   logic             aw_hs;
   logic             w_hs;
   logic             b_hs;
   logic             aw_done;
   logic             w_done;
   logic             unused_pkt_bits;

   emaxi_rr_arb #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_access),
      .upd       (accept),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   assign pkt     = req_packet[int'(grant_idx)*PKT_W +: PKT_W];
   assign accept  = !rst && (state == ST_IDLE) && grant_vld &&
                    (outst_cnt < 4'(MAX_OUTST));
   assign load    = accept && pkt[WRITE_BIT];
   assign drop    = accept && !pkt[WRITE_BIT];

   // B is always accepted outside reset, so bready is just the inverse of rst.
   assign m_axi_bready = ~rst;
   assign aw_hs        = m_axi_awvalid & m_axi_awready;
   assign w_hs         = m_axi_wvalid & m_axi_wready;
   assign b_hs         = m_axi_bvalid & m_axi_bready;
   assign aw_done      = !m_axi_awvalid || m_axi_awready;
   assign w_done       = !m_axi_wvalid || m_axi_wready;

   assign m_axi_awlen   = 8'd0;
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = CACHE_DEFAULT;
   assign m_axi_awprot  = 3'd0;
   assign m_axi_awqos   = 4'd0;
   assign m_axi_wlast   = m_axi_wvalid;

   // Access and ctrlmode carry no meaning for a single-beat AXI write.
   assign unused_pkt_bits = ^{pkt[ACCESS_BIT], pkt[CTRL_LSB +: CTRL_W]};

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // FSM next state: leave ISSUE once both channels have completed.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (load) state_nxt = ST_ISSUE;
         ST_ISSUE: if (aw_done && w_done) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: only the granted requester is released, and only when accepting.
   always_comb begin
      req_wait = '1;
      if (accept) req_wait[grant_idx] = 1'b0;
   end

   // AW and W valids rise together on load and drop independently on handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
      end else if (load) begin
         m_axi_awvalid <= 1'b1;
         m_axi_wvalid  <= 1'b1;
      end else begin
         if (aw_hs) m_axi_awvalid <= 1'b0;
         if (w_hs)  m_axi_wvalid  <= 1'b0;
      end
   end

   // Payload captured on load and held stable until the next load.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_axi_awid   <= '0;
         m_axi_awaddr <= '0;
         m_axi_awsize <= '0;
         m_axi_wdata  <= '0;
         m_axi_wstrb  <= '0;
      end else if (load) begin
         m_axi_awid   <= ID_W'(grant_idx);
         m_axi_awaddr <= pkt[DST_LSB +: ADDR_W];
         m_axi_awsize <= {1'b0, pkt[DM_LSB +: DM_W]};
         m_axi_wdata  <= pack_wdata(pkt[DM_LSB +: DM_W], pkt[DATA_LSB +: 32],
                                    pkt[SRC_LSB +: 32]);
         m_axi_wstrb  <= pack_wstrb(pkt[DM_LSB +: DM_W], pkt[DST_LSB +: 3]);
      end
   end

   // Outstanding-write count and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         outst_cnt  <= '0;
         err_sticky <= '0;
      end else begin
         case ({aw_hs, b_hs})
            2'b10: outst_cnt <= outst_cnt + 4'd1;
            2'b01: begin
               if (outst_cnt == 4'd0) err_sticky[1] <= 1'b1;
               else                   outst_cnt     <= outst_cnt - 4'd1;
            end
            default: outst_cnt <= outst_cnt;
         endcase
         if (b_hs && (m_axi_bresp == RESP_SLVERR || m_axi_bresp == RESP_DECERR))
            err_sticky[0] <= 1'b1;
         if (drop)
            err_sticky[2] <= 1'b1;
      end
   end

endmodule

// File: doc/emaxi_wr_sched.md
Name: emaxi_wr_sched

Overview:
- Scheduler in front of the EMesh-to-AXI write master.
- Arbitrates round-robin among NREQ EMesh write requesters and turns each granted 104-bit packet into one single-beat AXI write: AW and W channels handshaked independently.
- Bounds the number of writes awaiting a B response and flags protocol and packet errors.
- Sits between the EMesh write crossbar and the AXI interconnect port.

Parameters:
- NREQ, 2, number of EMesh write requesters (2..8).
- ID_W, 4, AXI ID width; must satisfy 2**ID_W >= NREQ.
- MAX_OUTST, 4, maximum AW-issued writes without B response (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_access  in  NREQ  per-requester packet valid.
- req_packet  in  NREQ*104  packets; requester i occupies [104*i+103:104*i].
- req_wait  out  NREQ  per-requester stall; packet consumed when access=1 and wait=0.
- m_axi_awid  out  ID_W  index of the granted requester.
- m_axi_awaddr  out  32  destination address.
- m_axi_awlen  out  8  always 0.
- m_axi_awsize  out  3  equal to datamode.
- m_axi_awburst  out  2  always 2'b01.
- m_axi_awlock  out  1  always 0.
- m_axi_awcache  out  4  always 4'b0011.
- m_axi_awprot  out  3  always 0.
- m_axi_awqos  out  4  always 0.
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address ready.
- m_axi_wdata  out  64  write data.
- m_axi_wstrb  out  8  byte strobes.
- m_axi_wlast  out  1  equal to m_axi_wvalid.
- m_axi_wvalid  out  1  data valid.
- m_axi_wready  in  1  data ready.
- m_axi_bvalid  in  1  response valid.
- m_axi_bresp  in  2  response code.
- m_axi_bready  out  1  response ready.
- outst_cnt  out  4  current outstanding count.
- err_sticky  out  3  bit0 SLVERR/DECERR seen; bit1 B with zero outstanding; bit2 non-write packet dropped.

Behaviour:
- Packet fields:
  - access [0], write [1], datamode [3:2], ctrlmode [7:4]
  - dstaddr [39:8], data [71:40], srcaddr [103:72]
- Reset values:
  - awvalid = wvalid = 0.
  - bready = 0 during the reset cycle, 1 in every cycle afterwards.
  - req_wait = all ones while rst is high.
  - outst_cnt = 0, err_sticky = 0, round-robin pointer = 0.
  - All AXI payload registers = 0.
- Reset mid-transaction drops the in-flight write silently; no recovery.
- FSM IDLE:
  - Grant goes to the lowest index i >= ptr (wrapping) with req_access[i]=1.
  - req_wait[i] = 0 only for the granted index, and only when outst_cnt < MAX_OUTST. All other requesters see wait=1.
  - Accept with write=1: register the payload and go to ISSUE. awvalid and wvalid both assert on the next cycle (1-cycle accept-to-valid latency).
  - Accept with write=0: discard the packet, set err_sticky[2], stay in IDLE.
  - After any accept, ptr = grant+1 mod NREQ.
- FSM ISSUE:
  - awvalid holds until awready; wvalid holds until wready. Each drops the cycle after its own handshake, in either order or simultaneously.
  - Payload is stable while its valid is high.
  - When both handshakes are complete, go to IDLE. No acceptance occurs in the cycle of the final handshake, so peak throughput is 1 write per 2 cycles.
- Data and strobe by size, with a = dstaddr[2:0]:
  - size 0: wdata = data[7:0] replicated x8; wstrb = 8'h01 << a.
  - size 1: wdata = data[15:0] x4; wstrb = 8'h03 << {a[2:1],1'b0}.
  - size 2: wdata = data x2; wstrb = 8'h0F << {a[2],2'b00}.
  - size 3: wdata = {srcaddr, data}; wstrb = 8'hFF.
  - Misaligned low address bits are passed through unchanged in awaddr.
- Outstanding counter:
  - +1 on an AW handshake; -1 on a B handshake; unchanged when both occur in the same cycle.
  - B handshake at 0: count stays 0 and err_sticky[1] sets.
- err_sticky[0] sets on any B handshake with bresp[1]=1.
- err_sticky bits clear only on rst.

Decomposition:
- Shared package emesh_axi_pkg:
  - packet width 104 and field bit-position constants;
  - AXI constant encodings (BURST_INCR, CACHE_DEFAULT, RESP_*).
- Sub-module emaxi_rr_arb: NREQ round-robin arbiter with a pointer-update enable, reused by the read-side scheduler.

Test Plan:
- Single write, size 2, dstaddr=0x1000_0004, data=0xDEADBEEF, awready and wready tied high → awaddr=0x1000_0004, awsize=2, wdata=0xDEADBEEF_DEADBEEF, wstrb=0xF0, awid=0; after bvalid with OKAY, outst_cnt returns to 0.
- Req0 and req1 both stream continuously → grants alternate 0,1,0,1; awid sequence matches; no requester is starved.
- wready delayed 3 cycles after awready → awvalid drops first, wvalid holds with stable payload; no new accept until the W handshake.
- bvalid held low, 6 requests queued, MAX_OUTST=4 → exactly 4 AW handshakes, req_wait stays 1; one bvalid pulse admits the 5th.
- Size-0 write to address 0x3 with data 0xA5 → wdata=0xA5A5A5A5A5A5A5A5, wstrb=0x08; size-3 write → wstrb=0xFF, wdata={srcaddr,data}.
- Error cases:
  - B with SLVERR → err_sticky[0]=1.
  - Spurious bvalid at count 0 → err_sticky[1]=1.
  - Packet with write=0 → dropped with no AXI activity and err_sticky[2]=1.
  - rst asserted during ISSUE → all valids 0 and all counters 0 next cycle.
